reg_file_sb: RTL and testbench

//  Parametrised multi-read-port integer register file with a per-register pending-write scoreboard.

---
 rtl/reg_file_sb.sv | 117 +++++++++++
 tb/tb_reg_file_sb.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with pending-write scoreboard, clear sweep and write bypass.
// Optional even parity per entry when REGFILE_PARITY_EN is defined.
module reg_file_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  input  logic [XLEN-1:0]      rd_data,
  input  logic                 set_vld,
  input  logic [$clog2(NREG)-1:0] set_addr,
  input  logic [NRD*$clog2(NREG)-1:0] rs_addr,
  output logic [NRD*XLEN-1:0]  rs_data,
  output logic [NRD-1:0]       rs_busy,
  output logic                 init_done,
  output logic [NRD-1:0]       par_err
);

  localparam int unsigned AW    = $clog2(NREG);
  localparam bit          BypEn = (BYPASS != 0);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [NREG-1:0][XLEN-1:0] mem_q;
  logic [NREG-1:0] pend_q;
`ifdef REGFILE_PARITY_EN
  logic [NREG-1:0] par_q;
`endif

  logic run;
  logic sweep;
  logic wr_en;

  // Outputs are masked combinationally while rst is high, even if the state is still RUN.
  assign run       = (state_q == StRun) && !rst;
  assign sweep     = (state_q == StClear) && !rst;
  assign wr_en     = run && we && (rd_addr != '0);
  assign init_done = run;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StClear: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NREG - 1)) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StClear;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage has no reset; the sweep zeroes it before the file becomes usable.
  always_ff @(posedge clk) begin
    if (sweep) begin
      mem_q[idx_q] <= '0;
`ifdef REGFILE_PARITY_EN
      par_q[idx_q] <= 1'b0;
`endif
    end else if (wr_en) begin
      mem_q[rd_addr] <= rd_data;
`ifdef REGFILE_PARITY_EN
      par_q[rd_addr] <= ^rd_data;
`endif
    end
  end

  // A set and a write to the same register in one cycle: the newer producer keeps it pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else if (state_q == StRun) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (set_vld && (set_addr == AW'(r))) begin
          pend_q[r] <= 1'b1;
        end else if (we && (rd_addr == AW'(r))) begin
          pend_q[r] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          live;
    logic          hit;

    assign addr = rs_addr[i*AW +: AW];
    assign live = run && (addr != '0);
    assign hit  = BypEn && wr_en && (addr == rd_addr);

    assign rs_data[i*XLEN +: XLEN] = !live ? '0 : (hit ? rd_data : mem_q[addr]);
    assign rs_busy[i]              = live && !hit && pend_q[addr];
`ifdef REGFILE_PARITY_EN
    assign par_err[i] = live && !hit && (^{par_q[addr], mem_q[addr]});
`else
    assign par_err[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: sweep/reset timing, vector table, random traffic against a model.
module tb_reg_file_sb;

  localparam int NREG = 32;
  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst, we, set_vld;
  logic [AW-1:0] rd_addr, set_addr;
  logic [XLEN-1:0] rd_data;
  logic [NRD*AW-1:0] rs_addr;

  logic [NRD*XLEN-1:0] d_b, d_n;
  logic [NRD-1:0] bsy_b, bsy_n, pe_b, pe_n;
  logic id_b, id_n;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: file contents, pending flags, and cycles elapsed since reset released.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_pend [NREG];
  int              m_since = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .set_vld(set_vld), .set_addr(set_addr), .rs_addr(rs_addr),
    .rs_data(d_b), .rs_busy(bsy_b), .init_done(id_b), .par_err(pe_b)
  );

  reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .rd_addr(rd_addr), .rd_data(rd_data),
    .set_vld(set_vld), .set_addr(set_addr), .rs_addr(rs_addr),
    .rs_data(d_n), .rs_busy(bsy_n), .init_done(id_n), .par_err(pe_n)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return (m_since >= NREG) && !rst;
  endfunction

  function automatic bit m_hit(input bit byp, input logic [AW-1:0] a);
    return byp && we && (rd_addr != 0) && (a == rd_addr);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input bit byp, input logic [AW-1:0] a);
    if (!m_ready() || a == 0) return '0;
    if (m_hit(byp, a)) return rd_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [AW-1:0] a);
    if (!m_ready() || a == 0 || m_hit(byp, a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check_model();
    logic [AW-1:0] a;
    cmp("init_done", id_b, m_ready());
    cmp("init_done_nb", id_n, m_ready());
    for (int i = 0; i < NRD; i++) begin
      a = rs_addr[i*AW +: AW];
      cmp($sformatf("rs_data%0d", i), d_b[i*XLEN +: XLEN], exp_data(1'b1, a));
      cmp($sformatf("rs_busy%0d", i), bsy_b[i], exp_busy(1'b1, a));
      cmp($sformatf("par_err%0d", i), pe_b[i], 1'b0);
      cmp($sformatf("rs_data%0d_nb", i), d_n[i*XLEN +: XLEN], exp_data(1'b0, a));
      cmp($sformatf("rs_busy%0d_nb", i), bsy_n[i], exp_busy(1'b0, a));
      cmp($sformatf("par_err%0d_nb", i), pe_n[i], 1'b0);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_since = 0;
      for (int r = 0; r < NREG; r++) begin
        m_mem[r]  = '0;
        m_pend[r] = 1'b0;
      end
    end else if (m_since < NREG) begin
      m_since++;
    end else begin
      if (we && rd_addr != 0) m_mem[rd_addr] = rd_data;
      for (int r = 1; r < NREG; r++) begin
        if (set_vld && set_addr == AW'(r)) m_pend[r] = 1'b1;
        else if (we && rd_addr == AW'(r))  m_pend[r] = 1'b0;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle_inputs();
    we = 0; rd_addr = '0; rd_data = '0; set_vld = 0; set_addr = '0;
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            sv;
    logic [AW-1:0]   sa;
    logic [AW-1:0]   r0, r1;
    logic [XLEN-1:0] e0, e1;
    logic [1:0]      eb;
    logic [XLEN-1:0] nb0;
  } vec_t;

  vec_t vt [15];

  initial begin
    vt[0]  = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0};
    vt[1]  = '{1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 5'd7, 5'd7,
               32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'hDEADBEEF, 2'b00, 32'h0};
    vt[3]  = '{1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd9, 5'd7,
               32'hA5A5A5A5, 32'hDEADBEEF, 2'b00, 32'h0};
    vt[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'hA5A5A5A5, 32'h0, 2'b00, 32'hA5A5A5A5};
    vt[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3, 32'h0, 32'h0, 2'b00, 32'h0};
    vt[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h0, 32'h0, 2'b11, 32'h0};
    vt[7]  = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd3, 5'd1, 32'h33, 32'h0, 2'b00, 32'h0};
    vt[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h33, 32'h33, 2'b00, 32'h33};
    vt[9]  = '{1'b1, 5'd3, 32'h44, 1'b1, 5'd3, 5'd3, 5'd2, 32'h44, 32'h0, 2'b00, 32'h33};
    vt[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3, 32'h44, 32'h44, 2'b11, 32'h44};
    vt[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h44, 2'b10, 32'h0};
    vt[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 32'h0};
    vt[13] = '{1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd4, 5'd3, 32'h0, 32'h55, 2'b00, 32'h0};
    vt[14] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd9, 32'h55, 32'hA5A5A5A5, 2'b00, 32'h55};

    for (int r = 0; r < NREG; r++) begin
      m_mem[r]  = '0;
      m_pend[r] = 1'b0;
    end
    rst = 1; idle_inputs(); rs_addr = '0;

    // Reset for three cycles, then a full sweep with a write to x5 attempted throughout.
    for (int c = 0; c < 3; c++) tick();
    rst = 0; we = 1; rd_addr = 5'd5; rd_data = 32'hFFFFFFFF; rs_addr = {5'd5, 5'd5};
    for (int c = 0; c <= NREG; c++) begin
      sample();
      cmp($sformatf("sweep_init_done_c%0d", c), id_b, (c >= NREG));
      advance();
      if (c == NREG - 1) we = 0;
    end
    for (int r = 1; r < NREG; r++) begin
      rs_addr = {AW'(r), AW'(r)};
      sample();
      cmp($sformatf("cleared_x%0d", r), d_b, '0);
      advance();
    end

    // Reset pulsed at sweep cycle 10 restarts the count.
    rst = 1; tick(); rst = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      cmp("midsweep_pre", id_b, 1'b0);
      advance();
    end
    rst = 1; tick(); rst = 0;
    for (int c = 0; c <= NREG; c++) begin
      sample();
      cmp($sformatf("resweep_init_done_c%0d", c), id_b, (c >= NREG));
      advance();
    end

    // Directed vector table.
    for (int k = 0; k < 15; k++) begin
      we = vt[k].we; rd_addr = vt[k].wa; rd_data = vt[k].wd;
      set_vld = vt[k].sv; set_addr = vt[k].sa; rs_addr = {vt[k].r1, vt[k].r0};
      sample();
      cmp($sformatf("vec%0d_d0", k), d_b[31:0], vt[k].e0);
      cmp($sformatf("vec%0d_d1", k), d_b[63:32], vt[k].e1);
      cmp($sformatf("vec%0d_busy", k), {30'd0, bsy_b}, {30'd0, vt[k].eb});
      cmp($sformatf("vec%0d_nb_d0", k), d_n[31:0], vt[k].nb0);
      advance();
    end

    // Random traffic, with occasional resets, against the model.
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 399) == 0);
      we       = $urandom_range(0, 1);
      rd_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      rd_data  = $urandom;
      set_vld  = ($urandom_range(0, 2) == 0);
      set_addr = AW'($urandom_range(0, 7));
      rs_addr  = {AW'($urandom_range(0, 7)), ($urandom_range(0, 1) == 0) ? rd_addr : AW'($urandom)};
      tick();
    end
    rst = 0; idle_inputs();
    for (int c = 0; c <= NREG; c++) tick();

    // Parity: x4 holds 0xF0 (even parity bit 0); flip stored bit 0.
    we = 1; rd_addr = 5'd4; rd_data = 32'h000000F0; rs_addr = {5'd7, 5'd4};
    tick();
    we = 0;
    sample();
`ifdef REGFILE_PARITY_EN
    force dut.mem_q[4][0] = 1'b1;
    #1;
    cmp("parity_err_port0", pe_b[0], 1'b1);
    cmp("parity_err_port1", pe_b[1], 1'b0);
    release dut.mem_q[4][0];
`else
    cmp("parity_off_port0", pe_b[0], 1'b0);
    cmp("parity_off_port1", pe_b[1], 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
